// File: rtl/vscale_htif_host_bridge_pkg.sv
// Shared HTIF bridge definitions: FSM and source encodings, tohost address, PCR width.
package vscale_htif_host_bridge_pkg;

    localparam int HTIF_PCR_WIDTH      = 64;
    localparam int HTIF_CSR_ADDR_WIDTH = 12;

    localparam logic [11:0] CSR_ADDR_TO_HOST = 12'h780;

    typedef enum logic [1:0] {
        HTIF_STATE_IDLE = 2'd0,
        HTIF_STATE_REQ  = 2'd1,
        HTIF_STATE_WAIT = 2'd2,
        HTIF_STATE_RSP  = 2'd3
    } htif_state_t;

    typedef enum logic {
        HTIF_SRC_CMD  = 1'b0,
        HTIF_SRC_POLL = 1'b1
    } htif_src_t;

    // An odd tohost word is an exit request; the code sits in bits [31:1].
    function automatic logic is_exit_word(input logic [HTIF_PCR_WIDTH-1:0] word);
        return word[0];
    endfunction

endpackage

// File: rtl/vscale_htif_poll_timer.sv
// Free-running tohost poll timer: raises poll_pending every POLL_INTERVAL cycles until it is consumed.
module vscale_htif_poll_timer #(
    parameter int POLL_INTERVAL = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic poll_pending
);

    localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = (POLL_INTERVAL > 0) ? CNT_W'(POLL_INTERVAL - 1) : '0;

    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign expire = (POLL_INTERVAL > 0) && (cnt == '0);

    // A new expiry wins over a same-cycle clear so that no poll is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= RELOAD;
            poll_pending <= 1'b0;
        end else begin
            cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
            if (expire) begin
                poll_pending <= 1'b1;
            end else if (clear) begin
                poll_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vscale_htif_host_bridge.sv
// Host-side HTIF PCR initiator: serialises host CSR commands onto the core PCR port and polls tohost.
// Build macro VSCALE_HTIF_TIMEOUT_EN adds a REQ/WAIT watchdog and the timeout_err output.
//
// state | meaning
// IDLE  | waiting for a host command or a pending tohost poll
// REQ   | presenting the latched request to the core
// WAIT  | waiting for the core response
// RSP   | holding the host result until rsp_ready
module vscale_htif_host_bridge
    import vscale_htif_host_bridge_pkg::*;
#(
    parameter int POLL_INTERVAL  = 64,
    parameter int CSR_ADDR_WIDTH = HTIF_CSR_ADDR_WIDTH,
    parameter int PCR_WIDTH      = HTIF_PCR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rw,
    input  logic [CSR_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [PCR_WIDTH-1:0]      cmd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PCR_WIDTH-1:0]      rsp_data,
    output logic                      htif_pcr_req_valid,
    input  logic                      htif_pcr_req_ready,
    output logic                      htif_pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
    output logic [PCR_WIDTH-1:0]      htif_pcr_req_data,
    input  logic                      htif_pcr_resp_valid,
    output logic                      htif_pcr_resp_ready,
    input  logic [PCR_WIDTH-1:0]      htif_pcr_resp_data,
    output logic                      tohost_valid,
    output logic [PCR_WIDTH-1:0]      tohost_data,
    output logic                      exit_valid,
`ifdef VSCALE_HTIF_TIMEOUT_EN
    output logic                      timeout_err,
`endif
    output logic [30:0]               exit_code
);

    htif_state_t                state_q, state_d;
    htif_src_t                  src_q;
    logic                       rw_q;
    logic [CSR_ADDR_WIDTH-1:0]  addr_q;
    logic [PCR_WIDTH-1:0]       data_q;
    logic [PCR_WIDTH-1:0]       rsp_data_q;
    logic                       tohost_valid_q;
    logic [PCR_WIDTH-1:0]       tohost_data_q;
    logic                       exit_valid_q;
    logic [30:0]                exit_code_q;
    logic                       poll_pending;
    logic                       poll_take;
    logic                       timeout_hit;
    logic                       timeout_abort;

    vscale_htif_poll_timer #(
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_poll_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (poll_take),
        .poll_pending (poll_pending)
    );

    assign timeout_abort = timeout_hit &&
                           (((state_q == HTIF_STATE_REQ)  && !htif_pcr_req_ready) ||
                            ((state_q == HTIF_STATE_WAIT) && !htif_pcr_resp_valid));

`ifdef VSCALE_HTIF_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        timeout_err_q;

    assign timeout_hit = (to_cnt_q == 16'hFFFF);
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (((state_q == HTIF_STATE_REQ) || (state_q == HTIF_STATE_WAIT)) && !timeout_hit) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end else begin
                to_cnt_q <= '0;
            end
            if (timeout_abort) begin
                timeout_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HTIF_STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HTIF_STATE_IDLE: begin
                if (cmd_valid || poll_take) begin
                    state_d = HTIF_STATE_REQ;
                end
            end
            HTIF_STATE_REQ: begin
                if (htif_pcr_req_ready) begin
                    state_d = HTIF_STATE_WAIT;
                end else if (timeout_abort) begin
                    state_d = (src_q == HTIF_SRC_CMD) ? HTIF_STATE_RSP : HTIF_STATE_IDLE;
                end
            end
            HTIF_STATE_WAIT: begin
                if (htif_pcr_resp_valid || timeout_abort) begin
                    state_d = (src_q == HTIF_SRC_CMD) ? HTIF_STATE_RSP : HTIF_STATE_IDLE;
                end
            end
            HTIF_STATE_RSP: begin
                if (rsp_ready) begin
                    state_d = HTIF_STATE_IDLE;
                end
            end
            default: state_d = HTIF_STATE_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready           = 1'b0;
        poll_take           = 1'b0;
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_resp_ready = 1'b0;
        rsp_valid           = 1'b0;
        case (state_q)
            HTIF_STATE_IDLE: begin
                cmd_ready = cmd_valid;
                poll_take = !cmd_valid && poll_pending && !exit_valid_q;
            end
            HTIF_STATE_REQ:  htif_pcr_req_valid  = 1'b1;
            HTIF_STATE_WAIT: htif_pcr_resp_ready = 1'b1;
            HTIF_STATE_RSP:  rsp_valid           = 1'b1;
            default: ;
        endcase
    end

    // Request latch and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q          <= HTIF_SRC_CMD;
            rw_q           <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            rsp_data_q     <= '0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= '0;
            exit_valid_q   <= 1'b0;
            exit_code_q    <= '0;
        end else begin
            tohost_valid_q <= 1'b0;
            if (state_q == HTIF_STATE_IDLE) begin
                if (cmd_valid) begin
                    src_q  <= HTIF_SRC_CMD;
                    rw_q   <= cmd_rw;
                    addr_q <= cmd_addr;
                    data_q <= cmd_data;
                end else if (poll_take) begin
                    src_q  <= HTIF_SRC_POLL;
                    rw_q   <= 1'b0;
                    addr_q <= CSR_ADDR_WIDTH'(CSR_ADDR_TO_HOST);
                    data_q <= '0;
                end
            end
            if ((state_q == HTIF_STATE_WAIT) && htif_pcr_resp_valid) begin
                if (src_q == HTIF_SRC_CMD) begin
                    rsp_data_q <= rw_q ? '0 : htif_pcr_resp_data;
                end else if (htif_pcr_resp_data != '0) begin
                    tohost_valid_q <= 1'b1;
                    tohost_data_q  <= htif_pcr_resp_data;
                    if (is_exit_word(HTIF_PCR_WIDTH'(htif_pcr_resp_data))) begin
                        exit_valid_q <= 1'b1;
                        exit_code_q  <= htif_pcr_resp_data[31:1];
                    end
                end
            end else if (timeout_abort && (src_q == HTIF_SRC_CMD)) begin
                rsp_data_q <= '1;
            end
        end
    end

    assign htif_pcr_req_rw   = rw_q;
    assign htif_pcr_req_addr = addr_q;
    assign htif_pcr_req_data = data_q;
    assign rsp_data          = rsp_data_q;
    assign tohost_valid      = tohost_valid_q;
    assign tohost_data       = tohost_data_q;
    assign exit_valid        = exit_valid_q;
    assign exit_code         = exit_code_q;

endmodule
